// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arbiter_rr_pkg: burst bus types, arbiter FSM states and burst limits
package bus_arbiter_rr_pkg;
  localparam int BUS_ADDR_W    = 32;
  localparam int BUS_DATA_W    = 32;
  localparam int BUS_BEAT_W    = 4;
  localparam int BUS_MAX_BURST = 15;

  typedef logic [BUS_BEAT_W-1:0] beat_cnt_t;

  typedef struct packed {
    logic                    arvalid;
    logic [BUS_ADDR_W-1:0]   araddr;
    beat_cnt_t               rlen;
    logic                    rready;
    logic                    awvalid;
    logic [BUS_ADDR_W-1:0]   waddr;
    beat_cnt_t               wlen;
    logic                    wvalid;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    bready;
  } bus_query_req_t;

  // rready here is the slave's read-address accept, not a data handshake
  typedef struct packed {
    logic                  rready;
    logic                  rvalid;
    logic                  rlast;
    logic [BUS_DATA_W-1:0] rdata;
    logic                  awready;
    logic                  wready;
    logic                  bvalid;
  } bus_query_resp_t;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: one-hot winner search from a start pointer with wrap-around
module rr_picker #(
  parameter int N          = 3,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int PW        = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);
  logic [PW-1:0] start, idx, win;
  assign valid_o = |req_i;
  // scan from the farthest slot back so the nearest requester at or after start wins
  always_comb begin
    start = FIXED_PRIO ? '0 : ptr_i;
    idx   = '0;
    win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(start) + i) % N);
      win = req_i[idx] ? idx : win;
    end
    gnt_o = valid_o ? N'(1) << win : '0;
  end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master to 1-slave burst arbiter with independent read and write channels
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int N_MASTERS  = 3,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  bus_query_req_t  [N_MASTERS-1:0]  m_req,
  output bus_query_resp_t [N_MASTERS-1:0]  m_resp,
  output bus_query_req_t                   s_req,
  input  bus_query_resp_t                  s_resp,
  output logic            [N_MASTERS-1:0]  rd_grant,
  output logic            [N_MASTERS-1:0]  wr_grant,
  output logic                             proto_err
);
  localparam int PW = $clog2(N_MASTERS);

  rd_state_t            rd_state_q;
  wr_state_t            wr_state_q;
  logic [N_MASTERS-1:0] rd_grant_q, wr_grant_q, ar_req, aw_req, rd_win, wr_win;
  logic [PW-1:0]        rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
  logic [PW-1:0]        rd_idx, wr_idx, rd_win_idx, wr_win_idx;
  beat_cnt_t            rd_beats_q, wr_beats_q;
  logic                 proto_err_q, rd_any, wr_any;
  logic                 rd_addr, rd_data, wr_addr, wr_data, wr_resp;
  logic                 rd_beat, wr_beat, rd_err, wr_err, wr_done;
  bus_query_req_t       rd_m, wr_m;

  function automatic logic [PW-1:0] oh2idx(input logic [N_MASTERS-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < N_MASTERS; i++) oh2idx = oh[i] ? oh2idx | PW'(i) : oh2idx;
  endfunction

  assign rd_grant  = rd_grant_q;
  assign wr_grant  = wr_grant_q;
  assign proto_err = proto_err_q;

  // eligible requesters: zero-length bursts are never granted
  always_comb begin
    ar_req = '0;
    aw_req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      ar_req[i] = m_req[i].arvalid && m_req[i].rlen != '0;
      aw_req[i] = m_req[i].awvalid && m_req[i].wlen != '0;
    end
  end

  rr_picker #(.N(N_MASTERS), .FIXED_PRIO(FIXED_PRIO)) u_rd_pick (
    .req_i(ar_req), .ptr_i(rd_ptr_q), .gnt_o(rd_win), .valid_o(rd_any)
  );

  rr_picker #(.N(N_MASTERS), .FIXED_PRIO(FIXED_PRIO)) u_wr_pick (
    .req_i(aw_req), .ptr_i(wr_ptr_q), .gnt_o(wr_win), .valid_o(wr_any)
  );

  // owner selection, handshake decode and next round-robin pointers
  always_comb begin
    rd_idx     = oh2idx(rd_grant_q);
    wr_idx     = oh2idx(wr_grant_q);
    rd_win_idx = oh2idx(rd_win);
    wr_win_idx = oh2idx(wr_win);
    rd_m       = m_req[rd_idx];
    wr_m       = m_req[wr_idx];
    rd_addr    = rd_state_q == R_ADDR;
    rd_data    = rd_state_q == R_DATA;
    wr_addr    = wr_state_q == W_ADDR;
    wr_data    = wr_state_q == W_DATA;
    wr_resp    = wr_state_q == W_RESP;
    rd_beat    = rd_data && s_resp.rvalid && rd_m.rready;
    wr_beat    = wr_data && wr_m.wvalid && s_resp.wready;
    rd_err     = rd_beat && (s_resp.rlast != (rd_beats_q == beat_cnt_t'(1)));
    wr_err     = wr_beat && (wr_m.wlast != (wr_beats_q == beat_cnt_t'(1)));
    wr_done    = wr_resp && s_resp.bvalid && wr_m.bready;
    rd_ptr_d   = FIXED_PRIO ? '0 : (rd_idx == PW'(N_MASTERS - 1) ? '0 : rd_idx + 1'b1);
    wr_ptr_d   = FIXED_PRIO ? '0 : (wr_idx == PW'(N_MASTERS - 1) ? '0 : wr_idx + 1'b1);
  end

  // read channel FSM: grant held from arbitration until the rlast beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_grant_q <= '0;
      rd_beats_q <= '0;
      rd_ptr_q   <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (rd_any) begin
          rd_grant_q <= rd_win;
          rd_beats_q <= m_req[rd_win_idx].rlen;
          rd_state_q <= R_ADDR;
        end
        R_ADDR: rd_state_q <= s_resp.rready ? R_DATA : R_ADDR;
        R_DATA: if (rd_beat) begin
          rd_beats_q <= s_resp.rlast || rd_beats_q == '0 ? '0 : rd_beats_q - 1'b1;
          rd_state_q <= s_resp.rlast ? R_IDLE : R_DATA;
          rd_grant_q <= s_resp.rlast ? '0 : rd_grant_q;
          rd_ptr_q   <= s_resp.rlast ? rd_ptr_d : rd_ptr_q;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // write channel FSM: grant held through the write response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_grant_q <= '0;
      wr_beats_q <= '0;
      wr_ptr_q   <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (wr_any) begin
          wr_grant_q <= wr_win;
          wr_beats_q <= m_req[wr_win_idx].wlen;
          wr_state_q <= W_ADDR;
        end
        W_ADDR: wr_state_q <= s_resp.awready ? W_DATA : W_ADDR;
        W_DATA: if (wr_beat) begin
          wr_beats_q <= wr_m.wlast || wr_beats_q == '0 ? '0 : wr_beats_q - 1'b1;
          wr_state_q <= wr_m.wlast ? W_RESP : W_DATA;
        end
        W_RESP: if (wr_done) begin
          wr_state_q <= W_IDLE;
          wr_grant_q <= '0;
          wr_ptr_q   <= wr_ptr_d;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // sticky burst-length mismatch flag from either channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err_q <= 1'b0;
    else proto_err_q <= proto_err_q | rd_err | wr_err;
  end

  // pass-through muxes steered by the registered grants; idle fields stay 0
  always_comb begin
    s_req         = '0;
    m_resp        = '0;
    s_req.arvalid = rd_addr && rd_m.arvalid;
    s_req.araddr  = rd_addr ? rd_m.araddr : '0;
    s_req.rlen    = rd_addr ? rd_m.rlen : '0;
    s_req.rready  = rd_data && rd_m.rready;
    s_req.awvalid = wr_addr && wr_m.awvalid;
    s_req.waddr   = wr_addr ? wr_m.waddr : '0;
    s_req.wlen    = wr_addr ? wr_m.wlen : '0;
    s_req.wvalid  = wr_data && wr_m.wvalid;
    s_req.wdata   = wr_data ? wr_m.wdata : '0;
    s_req.wstrb   = wr_data ? wr_m.wstrb : '0;
    s_req.wlast   = wr_data && wr_m.wlast;
    s_req.bready  = wr_resp && wr_m.bready;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_resp[i].rready  = rd_grant_q[i] && rd_addr && s_resp.rready;
      m_resp[i].rvalid  = rd_grant_q[i] && rd_data && s_resp.rvalid;
      m_resp[i].rlast   = rd_grant_q[i] && rd_data && s_resp.rlast;
      m_resp[i].rdata   = rd_grant_q[i] && rd_data ? s_resp.rdata : '0;
      m_resp[i].awready = wr_grant_q[i] && wr_addr && s_resp.awready;
      m_resp[i].wready  = wr_grant_q[i] && wr_data && s_resp.wready;
      m_resp[i].bvalid  = wr_grant_q[i] && wr_resp && s_resp.bvalid;
    end
  end
endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised N-master to 1-slave arbiter for the self-defined burst bus (`bus_query_req_t` / `bus_query_resp_t`). It sits between the cache/MMU masters (I-cache, D-cache, PTW, …) and the single memory-side bus port. Read and write channels are arbitrated independently, so one read burst and one write burst from different masters may be in flight at once. Each grant is held for a whole burst, and arbitration is round-robin or fixed-priority.

## Interface
- `N_MASTERS`, 3: number of master ports, 2..8.
- `FIXED_PRIO`, 0: 0 selects round-robin; 1 selects lowest index wins.
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `m_req`  in  N_MASTERS × bus_query_req_t: master requests.
- `m_resp`  out  N_MASTERS × bus_query_resp_t: master responses.
- `s_req`  out  bus_query_req_t: request to the slave.
- `s_resp`  in  bus_query_resp_t: slave response.
- `rd_grant`  out  N_MASTERS: one-hot read owner. All zeros when idle.
- `wr_grant`  out  N_MASTERS: one-hot write owner. All zeros when idle.
- `proto_err`  out  1: sticky flag for a burst-length mismatch. Cleared only by reset.

## Operation
- Read FSM states: `R_IDLE`, `R_ADDR`, `R_DATA`.
  - `R_IDLE`: choose a winner among masters with `arvalid=1` and `rlen!=0`. Register the winner in `rd_grant` and load `rbeats=rlen`. Go to `R_ADDR`.
  - `R_ADDR`: drive `s_req.arvalid`, `araddr` and `rlen` from the owner. When `s_resp.rready=1` (address accepted), pass that bit to the owner and go to `R_DATA`.
  - `R_DATA`: route `rvalid`, `rlast` and `rdata` to the owner, and route the owner's `rready` to the slave. A beat completes when `rvalid && rready`; each beat decrements `rbeats`.
  - On the beat with `rlast`, go to `R_IDLE`.
  - If `rlast` arrives while `rbeats!=1`, or `rbeats` reaches 0 without `rlast`, set `proto_err`. The FSM still goes idle, on `rlast` only.
- Write FSM states: `W_IDLE`, `W_ADDR`, `W_DATA`, `W_RESP`.
  - `W_IDLE`: choose a winner among masters with `awvalid=1` and `wlen!=0`. Load `wbeats=wlen`.
  - `W_ADDR`: forward `awvalid`, `waddr` and `wlen`. On `awready`, go to `W_DATA`.
  - `W_DATA`: forward `wvalid`, `wdata`, `wstrb` and `wlast`, and return `wready`. Each `wvalid && wready` beat decrements `wbeats`. On the `wlast` beat, go to `W_RESP`. A `wlast`/`wbeats` mismatch sets `proto_err`.
  - `W_RESP`: forward `bvalid` and `bready`. When both are 1, go to `W_IDLE`.
- Arbitration:
  - With round-robin, search from `rr_ptr` upward with wrap-around.
  - At burst completion, `rr_ptr = owner+1`, wrapping to 0 after `N_MASTERS-1`.
  - Read and write have separate pointers.
  - With `FIXED_PRIO=1`, the pointers are ignored and stay 0.
- Non-owner masters:
  - All response fields for the idle channel are 0.
  - Their requests are held unacknowledged, with no drop and no buffering.
- Slave-side fields of an idle channel are driven 0.
- Beat counters are 4 bits wide; `wlen`/`rlen` range 1..15 and give the beat count directly.

## Timing
- A request sampled in an IDLE cycle produces slave `arvalid`/`awvalid` on the next cycle. Arbitration latency is 1 cycle, and grant is registered.
- Data-phase paths (`rdata`, `rvalid`, `rready`, `wdata`, `wready`, `bvalid`, `bready`) are combinational pass-through muxes selected by the registered grant. They add no per-beat latency.
- Back-to-back bursts have 1 idle cycle between them, the IDLE arbitration cycle.
- A read and a write may both be granted in the same cycle, to the same master or different masters.
- A master that drops `arvalid`/`awvalid` after grant violates protocol. The FSM stays in ADDR, and this case is not checked.
- Reset, asserted at any time, immediately sets:
  - both FSMs to IDLE,
  - grants to 0,
  - `rr_ptr`s to 0,
  - counters to 0,
  - `proto_err` to 0,
  - all `s_req` and `m_resp` outputs to 0.
- A burst in progress at reset is abandoned; the slave is expected to be reset together with the arbiter.

## Structure
- Add to `bundle`:
  - `rd_state_t`,
  - `wr_state_t`,
  - a `BUS_MAX_BURST = 15` localparam.
- Sub-module `rr_picker`: combinational, parametrised on N, taking request vector and pointer and returning a one-hot winner plus a valid flag. It is instantiated twice, once for read and once for write, and honours `FIXED_PRIO` by forcing pointer 0.

## Test plan
- Single read: M1 issues `rlen=4`. Required: `rd_grant=3'b010` one cycle later; 4 data beats reach M1 with the `rdata` values intact; FSM back in `R_IDLE` after `rlast`; `rr_ptr=2`.
- Contention: M0, M1 and M2 issue simultaneous 2-beat reads from reset with round-robin. Required: grant order 0, 1, 2 and a repeat of 0 only after 2. With `FIXED_PRIO=1` and M0 requesting continuously, M0 wins every time.
- Concurrent channels: M0 does an 8-beat write while M2 does a 4-beat read. Required: both `rd_grant` and `wr_grant` asserted, no beat corruption, and the `bvalid` handshake reaches M0 only.
- Backpressure: the slave toggles `rvalid`/`wready` every other cycle, and the master holds `rready` low for 3 cycles. Required: the beat count stays exact and no beats are lost or duplicated.
- Protocol error: the slave asserts `rlast` on beat 2 of an `rlen=4` read. Required: `proto_err=1` sticky and FSM returns to `R_IDLE`; a subsequent read still succeeds.
- Reset mid-burst: assert `rst` during beat 3 of a write. Required: all outputs 0 in the same cycle, grants 0, and the next request is granted normally after reset release.
